fib_sequencer: RTL and testbench

FIB_SEQUENCER -- requirements
Module: fib_sequencer

---
 rtl/fib_pkg.sv | 20 ++
 rtl/fib_fifo.sv | 58 +++++
 rtl/fib_sequencer.sv | 135 +++++++++++++
 tb/tb_fib_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci capture sequencer: FSM encoding,
// interrupt bit positions and the default datapath width.
package fib_pkg;

  localparam int FIB_DATA_W = 30;

  // Positions inside the 3-bit irq vector {timeout, overflow, done}
  localparam int IRQ_DONE = 0;
  localparam int IRQ_OVF  = 1;
  localparam int IRQ_TMO  = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_STEP  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/fib_fifo.sv
// Show-ahead capture FIFO: head is visible whenever not empty, and a push
// into a full FIFO succeeds only when a pop frees a slot in the same cycle.
module fib_fifo
  import fib_pkg::*;
#(
  parameter int DATA_W = FIB_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic                   wb_clk_i,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [DATA_W-1:0]      data_i,
  output logic [DATA_W-1:0]      head_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [LW-1:0]     level_q;
  logic              do_push;
  logic              do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && !reset && (!full_o || do_pop);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_q + LW'(do_push) - LW'(do_pop);
    end
  end

  // NOTE: the storage array has no reset; stale contents are never visible
  // because the head is forced to zero while the FIFO is empty.
  always_ff @(posedge wb_clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/fib_sequencer.sv
// Run controller for an external Fibonacci datapath: clears/steps it, captures
// each acknowledged value into a show-ahead FIFO and raises pulse interrupts.
module fib_sequencer
  import fib_pkg::*;
#(
  parameter int DATA_W = FIB_DATA_W,
  parameter int DEPTH  = 4,
  parameter int TMO_W  = 8
) (
  input  logic                   wb_clk_i,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [7:0]             cmd_count,
  input  logic                   cmd_clear,
  input  logic                   cmd_abort,
  output logic                   fib_clear,
  output logic                   fib_step,
  input  logic                   fib_ack,
  input  logic [DATA_W-1:0]      fib_val,
  input  logic                   rd_en,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_empty,
  output logic [$clog2(DEPTH):0] rd_level,
  output logic                   busy,
  output logic [7:0]             remaining,
  output logic [2:0]             irq
);

  state_e           state_q;
  logic [7:0]       remaining_q;
  logic [TMO_W-1:0] tmo_q;
  logic             fib_clear_q;
  logic             fib_step_q;
  logic [2:0]       irq_q;

  logic capture;
  logic fifo_full;
  logic fifo_ovf;

  // An ack only counts while waiting for one; a full FIFO with a pop still has room.
  assign capture  = (state_q == ST_WAIT) && fib_ack;
  assign fifo_ovf = capture && fifo_full && !rd_en;

  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      tmo_q       <= '0;
      fib_clear_q <= 1'b0;
      fib_step_q  <= 1'b0;
      irq_q       <= '0;
    end else begin
      fib_clear_q     <= 1'b0;
      fib_step_q      <= 1'b0;
      irq_q           <= '0;
      irq_q[IRQ_OVF]  <= fifo_ovf;
      if (capture) remaining_q <= remaining_q - 8'd1;

      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            remaining_q <= cmd_count;
            if (cmd_count == 8'd0) begin
              state_q         <= ST_DONE;
              irq_q[IRQ_DONE] <= 1'b1;
            end else if (cmd_clear) begin
              state_q     <= ST_CLEAR;
              fib_clear_q <= 1'b1;
            end else begin
              state_q    <= ST_STEP;
              fib_step_q <= 1'b1;
            end
          end
        end
        ST_CLEAR: begin
          if (cmd_abort) begin
            state_q <= ST_IDLE;
          end else begin
            state_q    <= ST_STEP;
            fib_step_q <= 1'b1;
          end
        end
        ST_STEP: begin
          tmo_q   <= '1;
          state_q <= cmd_abort ? ST_IDLE : ST_WAIT;
        end
        ST_WAIT: begin
          // Abort wins over completion and timeout; a same-cycle ack is still captured.
          if (cmd_abort) begin
            state_q <= ST_IDLE;
          end else if (capture) begin
            if (remaining_q == 8'd1) begin
              state_q         <= ST_DONE;
              irq_q[IRQ_DONE] <= 1'b1;
            end else begin
              state_q    <= ST_STEP;
              fib_step_q <= 1'b1;
            end
          end else if (tmo_q == TMO_W'(1)) begin
            state_q        <= ST_IDLE;
            irq_q[IRQ_TMO] <= 1'b1;
          end else begin
            tmo_q <= tmo_q - TMO_W'(1);
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  fib_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .wb_clk_i (wb_clk_i),
    .reset    (reset),
    .push_i   (capture),
    .pop_i    (rd_en),
    .data_i   (fib_val),
    .head_o   (rd_data),
    .empty_o  (rd_empty),
    .full_o   (fifo_full),
    .level_o  (rd_level)
  );

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign remaining = remaining_q;
  assign fib_clear = fib_clear_q;
  assign fib_step  = fib_step_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_fib_sequencer.sv
// Directed bench for fib_sequencer: a small Fibonacci datapath model answers
// steps, and a scoreboard queue mirrors the expected capture FIFO contents.
module tb_fib_sequencer;
  import fib_pkg::*;

  localparam int DATA_W = 30;
  localparam int DEPTH  = 4;
  localparam int TMO_W  = 8;
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  logic              wb_clk_i;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [7:0]        cmd_count;
  logic              cmd_clear;
  logic              cmd_abort;
  logic              fib_clear;
  logic              fib_step;
  logic              fib_ack;
  logic [DATA_W-1:0] fib_val;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_empty;
  logic [LVL_W-1:0]  rd_level;
  logic              busy;
  logic [7:0]        remaining;
  logic [2:0]        irq;

  fib_sequencer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .TMO_W  (TMO_W)
  ) dut (
    .wb_clk_i  (wb_clk_i),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_count (cmd_count),
    .cmd_clear (cmd_clear),
    .cmd_abort (cmd_abort),
    .fib_clear (fib_clear),
    .fib_step  (fib_step),
    .fib_ack   (fib_ack),
    .fib_val   (fib_val),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_empty  (rd_empty),
    .rd_level  (rd_level),
    .busy      (busy),
    .remaining (remaining),
    .irq       (irq)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  int vectors;
  int miscompares;

  logic [DATA_W-1:0] sb_q[$];
  logic [DATA_W-1:0] fa;
  logic [DATA_W-1:0] fb;
  bit                ack_en;

  int cyc;
  int n_clear;
  int n_step;
  int n_acks;
  int first_step;
  int last_step;
  int n_irq [3];
  int irq_cyc [3];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_tally();
    cyc        = 0;
    n_clear    = 0;
    n_step     = 0;
    n_acks     = 0;
    first_step = -1;
    last_step  = -1;
    for (int k = 0; k < 3; k++) begin
      n_irq[k]   = 0;
      irq_cyc[k] = -1;
    end
  endtask

  // One clock: tally what the DUT shows after the edge, then answer a step
  // seen in the previous cycle with an ack during the WAIT cycle.
  task automatic cycle();
    bit step_now;
    bit ack_now;
    step_now = (fib_step === 1'b1);
    ack_now  = (fib_ack === 1'b1);
    @(posedge wb_clk_i);
    #1;
    cyc++;
    if (ack_now) n_acks++;
    if (fib_clear === 1'b1) begin
      n_clear++;
      fa = '0;
      fb = DATA_W'(1);
    end
    if (fib_step === 1'b1) begin
      n_step++;
      if (first_step < 0) first_step = cyc;
      last_step = cyc;
    end
    for (int k = 0; k < 3; k++) begin
      if (irq[k] === 1'b1) begin
        n_irq[k]++;
        if (irq_cyc[k] < 0) irq_cyc[k] = cyc;
      end
    end
    if (ack_en && step_now) begin
      fib_ack = 1'b1;
      fib_val = fa;
      if (sb_q.size() < DEPTH) sb_q.push_back(fa);
      {fa, fb} = {fb, fa + fb};
    end else begin
      fib_ack = 1'b0;
    end
  endtask

  task automatic start(input logic [7:0] cnt, input logic clr);
    cmd_valid = 1'b1;
    cmd_count = cnt;
    cmd_clear = clr;
    cycle();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_irq(input int bit_idx, input int budget, input string tag);
    int t0;
    t0 = cyc;
    while (n_irq[bit_idx] == 0 && (cyc - t0) < budget) cycle();
    check(tag, 64'(n_irq[bit_idx] > 0), 64'(1));
  endtask

  task automatic drain(input int n, input string tag);
    logic [DATA_W-1:0] exp_v;
    ack_en = 1'b0;
    for (int i = 0; i < n; i++) begin
      exp_v = '0;
      if (sb_q.size() > 0) exp_v = sb_q.pop_front();
      check(tag, 64'(rd_data), 64'(exp_v));
      rd_en = 1'b1;
      cycle();
      rd_en = 1'b0;
    end
    check({tag, "_empty"}, 64'(rd_empty), 64'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_count = '0;
    cmd_clear = 1'b0;
    cmd_abort = 1'b0;
    fib_ack   = 1'b0;
    fib_val   = '0;
    rd_en     = 1'b0;
    ack_en    = 1'b0;
    fa        = '0;
    fb        = DATA_W'(1);
    clr_tally();

    // Reset state
    cycle();
    cycle();
    check("rst_ready",     64'(cmd_ready), 64'(1));
    check("rst_busy",      64'(busy),      64'(0));
    check("rst_remaining", 64'(remaining), 64'(0));
    check("rst_empty",     64'(rd_empty),  64'(1));
    check("rst_level",     64'(rd_level),  64'(0));
    check("rst_data",      64'(rd_data),   64'(0));
    check("rst_step",      64'(fib_step),  64'(0));
    check("rst_clear",     64'(fib_clear), 64'(0));
    check("rst_irq",       64'(irq),       64'(0));
    reset = 1'b0;
    cycle();

    // Five values with clear, no pops: fifth push overflows a 4-deep FIFO
    clr_tally();
    ack_en = 1'b1;
    start(8'd5, 1'b1);
    check("run5_clear_pulse", 64'(fib_clear), 64'(1));
    check("run5_busy",        64'(busy),      64'(1));
    check("run5_ready",       64'(cmd_ready), 64'(0));
    check("run5_remaining",   64'(remaining), 64'(5));
    wait_irq(IRQ_DONE, 60, "run5_done_seen");
    check("run5_n_clear",  64'(n_clear),              64'(1));
    check("run5_n_step",   64'(n_step),               64'(5));
    check("run5_cadence",  64'(last_step - first_step), 64'(8));
    check("run5_ovf_irq",  64'(n_irq[IRQ_OVF]),       64'(1));
    check("run5_level",    64'(rd_level),             64'(4));
    check("run5_rem_zero", 64'(remaining),            64'(0));
    ack_en = 1'b0;
    cycle();
    check("run5_idle_busy", 64'(busy),            64'(0));
    check("run5_done_once", 64'(n_irq[IRQ_DONE]), 64'(1));
    drain(4, "run5_rd");
    rd_en = 1'b1;
    cycle();
    rd_en = 1'b0;
    check("pop_empty_level", 64'(rd_level), 64'(0));
    check("pop_empty_data",  64'(rd_data),  64'(0));

    // Abort after the third ack
    clr_tally();
    ack_en = 1'b1;
    start(8'd10, 1'b1);
    while (n_acks < 3 && cyc < 50) cycle();
    check("abort_acks", 64'(n_acks), 64'(3));
    ack_en    = 1'b0;
    cmd_abort = 1'b1;
    cycle();
    cmd_abort = 1'b0;
    check("abort_busy",      64'(busy),      64'(0));
    check("abort_remaining", 64'(remaining), 64'(7));
    check("abort_level",     64'(rd_level),  64'(3));
    // Ack while idle must be ignored
    fib_ack = 1'b1;
    fib_val = DATA_W'(123);
    cycle();
    cycle();
    check("idle_ack_level", 64'(rd_level),  64'(3));
    check("idle_ack_rem",   64'(remaining), 64'(7));
    check("abort_no_irq",   64'(n_irq[0] + n_irq[1] + n_irq[2]), 64'(0));
    drain(3, "abort_rd");

    // No acks at all: timeout after 255 WAIT cycles
    clr_tally();
    start(8'd3, 1'b0);
    wait_irq(IRQ_TMO, 300, "tmo_seen");
    check("tmo_latency",   64'(irq_cyc[IRQ_TMO] - first_step), 64'(256));
    check("tmo_busy",      64'(busy),            64'(0));
    check("tmo_remaining", 64'(remaining),       64'(3));
    check("tmo_empty",     64'(rd_empty),        64'(1));
    check("tmo_n_step",    64'(n_step),          64'(1));
    check("tmo_no_done",   64'(n_irq[IRQ_DONE]), 64'(0));

    // Full FIFO with pop and push in the same cycle
    clr_tally();
    ack_en = 1'b1;
    start(8'd4, 1'b1);
    wait_irq(IRQ_DONE, 40, "fill_done_seen");
    ack_en = 1'b0;
    cycle();
    check("fill_level", 64'(rd_level), 64'(4));
    clr_tally();
    start(8'd1, 1'b0);
    cycle();
    fib_ack = 1'b1;
    fib_val = fa;
    rd_en   = 1'b1;
    check("pp_head_before", 64'(rd_data), 64'(sb_q.pop_front()));
    sb_q.push_back(fa);
    {fa, fb} = {fb, fa + fb};
    cycle();
    rd_en = 1'b0;
    check("pp_level",      64'(rd_level), 64'(4));
    check("pp_head_after", 64'(rd_data),  64'(sb_q[0]));
    cycle();
    check("pp_no_ovf",  64'(n_irq[IRQ_OVF]),  64'(0));
    check("pp_done",    64'(n_irq[IRQ_DONE]), 64'(1));
    drain(4, "pp_rd");

    // Zero-length run
    clr_tally();
    start(8'd0, 1'b0);
    check("zero_done_irq", 64'(irq[IRQ_DONE]), 64'(1));
    check("zero_busy",     64'(busy),          64'(1));
    cycle();
    check("zero_idle",   64'(busy),   64'(0));
    check("zero_n_step", 64'(n_step), 64'(0));

    // Reset in WAIT with a pending ack clears everything
    clr_tally();
    ack_en = 1'b1;
    start(8'd2, 1'b1);
    wait_irq(IRQ_DONE, 20, "pre_rst_done_seen");
    ack_en = 1'b0;
    cycle();
    check("pre_rst_level", 64'(rd_level), 64'(2));
    start(8'd2, 1'b1);
    cycle();
    cycle();
    fib_ack = 1'b1;
    fib_val = DATA_W'(77);
    reset   = 1'b1;
    @(posedge wb_clk_i);
    #1;
    reset   = 1'b0;
    fib_ack = 1'b0;
    sb_q.delete();
    check("mrst_empty",     64'(rd_empty),  64'(1));
    check("mrst_level",     64'(rd_level),  64'(0));
    check("mrst_data",      64'(rd_data),   64'(0));
    check("mrst_busy",      64'(busy),      64'(0));
    check("mrst_remaining", 64'(remaining), 64'(0));
    check("mrst_irq",       64'(irq),       64'(0));
    check("mrst_step",      64'(fib_step),  64'(0));
    clr_tally();
    cycle();
    cycle();
    check("mrst_quiet", 64'(n_irq[0] + n_irq[1] + n_irq[2] + n_step), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
